// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access stage: access kinds, FSM states
// and the byte-lane map used by both store byte enables and load byte extraction.
package mem_access_unit_pkg;

  // Access kind carried down the pipeline in the mem_label field
  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_LOAD = 2'b01,
    MEM_SW   = 2'b10,
    MEM_SB   = 2'b11
  } mem_label_e;

  // Memory stage controller states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mau_state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Byte offset n within a word lives in lane n: ram_be bit n, data bits 8n+7:8n
  function automatic logic [3:0] lane_be(input logic [1:0] offset);
    return 4'b0001 << offset;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] offset);
    return word[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/load_align.sv
// Turns a raw read word into the write-back value: whole word for a load
// word, zero-extended lane byte for a load byte unsigned.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic        lbu,
  output logic [31:0] value
);

  // Select either the full word or the addressed lane, zero-extended
  always_comb begin
    value = rdata;
    if (lbu) begin
      value = {24'b0, lane_byte(rdata, offset)};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of the pipeline: issues loads/stores to a handshaked RAM port,
// stalls the upstream pipeline while the RAM is slow, aborts on misalignment
// or timeout, and holds the MEM/WB pipeline register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic [31:0] ram_write,
  input  logic [4:0]  rw,
  input  logic        we,
  input  logic        syscall,
  input  logic        lbu,
  input  logic        jal,
  input  logic [1:0]  mem_label,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic        stall,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_value,
  output logic [4:0]  wb_rw,
  output logic        wb_we,
  output logic        wb_syscall,
  output logic        wb_jal,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mau_state_e state, next_state;
  mem_label_e kind;

  logic             is_load, is_sw, access, misaligned, access_ok;
  logic [3:0]       cur_be;
  logic [31:0]      cur_wdata;
  logic             cur_we;
  logic             launch, timeout_hit, abort_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0] result_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q, load_q, lbu_q;

  logic [1:0]  la_offset;
  logic        la_lbu;
  logic [31:0] load_value;
  logic [31:0] wb_value_n;
  logic        wb_we_n;

  assign kind       = mem_label_e'(mem_label);
  assign is_load    = (kind == MEM_LOAD);
  assign is_sw      = (kind == MEM_SW);
  assign access     = (kind != MEM_NONE);
  assign misaligned = (result[1:0] != 2'b00) && ((is_load && !lbu) || is_sw);
  assign access_ok  = access && !misaligned;

  assign launch      = (state == IDLE) && !abort_q && access_ok && !ram_ack;
  assign timeout_hit = (state == WAIT) && !ram_ack && (wait_cnt == CNT_W'(TIMEOUT));

  // Byte enables, write data and direction for the access presented this cycle
  always_comb begin
    cur_be    = BE_WORD;
    cur_wdata = 32'b0;
    cur_we    = 1'b0;
    case (kind)
      MEM_SW: begin
        cur_wdata = ram_write;
        cur_we    = 1'b1;
      end
      MEM_SB: begin
        cur_be    = lane_be(result[1:0]);
        cur_wdata = {4{ram_write[7:0]}};
        cur_we    = 1'b1;
      end
      default: begin
        cur_be    = BE_WORD;
        cur_wdata = 32'b0;
        cur_we    = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Leave IDLE only when the RAM did not answer in the request cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = WAIT;
      WAIT:    if (ram_ack || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM port, stall and error pulses; a timed-out access is reported while
  // still stalled and released in the following cycle
  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 30'b0;
    ram_be    = BE_NONE;
    ram_wdata = 32'b0;
    stall     = 1'b0;
    align_err = 1'b0;
    bus_err   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (!abort_q) begin
            if (access_ok) begin
              ram_req   = 1'b1;
              ram_we    = cur_we;
              ram_addr  = result[31:2];
              ram_be    = cur_be;
              ram_wdata = cur_wdata;
              stall     = !ram_ack;
            end else if (access) begin
              align_err = 1'b1;
            end
          end
        end
        WAIT: begin
          if (timeout_hit) begin
            bus_err = 1'b1;
            stall   = 1'b1;
          end else begin
            ram_req   = 1'b1;
            ram_we    = we_q;
            ram_addr  = result_q[31:2];
            ram_be    = be_q;
            ram_wdata = wdata_q;
            stall     = !ram_ack;
          end
        end
        default: begin
          ram_req = 1'b0;
        end
      endcase
    end
  end

  // Capture the request when it has to wait, count wait cycles, flag an abort
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q  <= 1'b0;
      wait_cnt <= '0;
      result_q <= 32'b0;
      wdata_q  <= 32'b0;
      be_q     <= BE_NONE;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      lbu_q    <= 1'b0;
    end else begin
      abort_q <= timeout_hit;
      if (launch) begin
        result_q <= result;
        wdata_q  <= cur_wdata;
        be_q     <= cur_be;
        we_q     <= cur_we;
        load_q   <= is_load;
        lbu_q    <= lbu;
        wait_cnt <= CNT_W'(1);
      end else if ((state == WAIT) && !ram_ack && !timeout_hit) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign la_offset = (state == WAIT) ? result_q[1:0] : result[1:0];
  assign la_lbu    = (state == WAIT) ? lbu_q : lbu;

  load_align u_load_align (
    .rdata  (ram_rdata),
    .offset (la_offset),
    .lbu    (la_lbu),
    .value  (load_value)
  );

  // Value and write enable headed for write-back; failed accesses never write
  always_comb begin
    wb_value_n = result;
    wb_we_n    = we;
    if (state == WAIT) begin
      wb_value_n = load_q ? load_value : result_q;
    end else if (abort_q || (access && misaligned)) begin
      wb_we_n = 1'b0;
    end else if (access_ok && is_load) begin
      wb_value_n = load_value;
    end
  end

  // MEM/WB register advances whenever the pipeline is not stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_pc      <= 32'b0;
      wb_value   <= 32'b0;
      wb_rw      <= 5'b0;
      wb_we      <= 1'b0;
      wb_syscall <= 1'b0;
      wb_jal     <= 1'b0;
    end else if (!stall) begin
      wb_pc      <= pc;
      wb_value   <= wb_value_n;
      wb_rw      <= rw;
      wb_we      <= wb_we_n;
      wb_syscall <= syscall;
      wb_jal     <= jal;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, result, ram_write, ram_rdata;
  logic [4:0]  rw;
  logic        we, syscall, lbu, jal, ram_ack;
  logic [1:0]  mem_label;
  logic        ram_req, ram_we, stall, align_err, bus_err;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, wb_pc, wb_value;
  logic [4:0]  wb_rw;
  logic        wb_we, wb_syscall, wb_jal;

  int check_count = 0;
  int pass_count  = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pc(pc), .result(result), .ram_write(ram_write),
    .rw(rw), .we(we), .syscall(syscall), .lbu(lbu), .jal(jal),
    .mem_label(mem_label), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .stall(stall),
    .wb_pc(wb_pc), .wb_value(wb_value), .wb_rw(wb_rw), .wb_we(wb_we),
    .wb_syscall(wb_syscall), .wb_jal(wb_jal),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] a_pc, input logic [31:0] a_result,
                               input logic [31:0] a_wdata, input logic [4:0] a_rw,
                               input logic a_we, input logic a_lbu, input logic a_syscall,
                               input logic a_jal, input logic [1:0] a_label,
                               input logic a_ack, input logic [31:0] a_rdata);
    pc = a_pc; result = a_result; ram_write = a_wdata; rw = a_rw;
    we = a_we; lbu = a_lbu; syscall = a_syscall; jal = a_jal;
    mem_label = a_label; ram_ack = a_ack; ram_rdata = a_rdata;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0000_0AA0, 32'h0000_0010, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, MEM_LOAD, 1'b0, 32'h0);
    next_cycle();
    next_cycle(); #2;
    $display("[TB] reset");
    checkOutput("rst_ram_req", ram_req, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_ram_be", ram_be, 0);
    checkOutput("rst_wb_pc", wb_pc, 0);
    checkOutput("rst_wb_we", wb_we, 0);
    checkOutput("rst_wb_syscall", wb_syscall, 0);
    checkOutput("rst_errs", {align_err, bus_err}, 0);

    // Store word, zero wait
    next_cycle();
    rst = 1'b0;
    applyStimulus(32'h0000_1000, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_SW, 1'b1, 32'h0);
    $display("[TB] store word");
    checkOutput("sw_req", ram_req, 1);
    checkOutput("sw_we", ram_we, 1);
    checkOutput("sw_addr", ram_addr, 32'h40);
    checkOutput("sw_be", ram_be, 4'hF);
    checkOutput("sw_wdata", ram_wdata, 32'hDEAD_BEEF);
    checkOutput("sw_stall", stall, 0);
    next_cycle();
    applyStimulus(32'h0000_1004, 32'h0000_0055, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, MEM_NONE, 1'b0, 32'h0);
    checkOutput("sw_wb_pc", wb_pc, 32'h1000);
    checkOutput("sw_wb_value", wb_value, 32'h100);
    checkOutput("sw_idle_req", ram_req, 0);

    // Load byte unsigned at offset 3, ack three cycles after the request
    next_cycle();
    applyStimulus(32'h0000_2000, 32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, MEM_LOAD, 1'b0, 32'h1122_3344);
    $display("[TB] lbu with wait");
    checkOutput("lbu_wb_pc_prev", wb_pc, 32'h1004);
    checkOutput("lbu_wb_sys_prev", {wb_syscall, wb_jal}, 2'b11);
    checkOutput("lbu_req", ram_req, 1);
    checkOutput("lbu_we", ram_we, 0);
    checkOutput("lbu_be", ram_be, 4'hF);
    checkOutput("lbu_stall0", stall, 1);
    next_cycle();
    result = 32'hFFFF_FFF0; #2;
    checkOutput("lbu_hold_addr", ram_addr, 32'h40);
    checkOutput("lbu_stall1", stall, 1);
    next_cycle(); #2;
    checkOutput("lbu_stall2", stall, 1);
    checkOutput("lbu_req2", ram_req, 1);
    next_cycle();
    ram_ack = 1'b1; #2;
    checkOutput("lbu_ack_stall", stall, 0);
    next_cycle();
    applyStimulus(32'h0000_2004, 32'h0000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_NONE, 1'b0, 32'h0);
    checkOutput("lbu_wb_value", wb_value, 32'h0000_0011);
    checkOutput("lbu_wb_we", wb_we, 1);
    checkOutput("lbu_wb_rw", wb_rw, 5);
    checkOutput("lbu_wb_pc", wb_pc, 32'h2000);

    // Misaligned load word and store word
    next_cycle();
    applyStimulus(32'h0000_3000, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, MEM_LOAD, 1'b0, 32'h0);
    $display("[TB] misaligned");
    checkOutput("lw_mis_req", ram_req, 0);
    checkOutput("lw_mis_align", align_err, 1);
    checkOutput("lw_mis_stall", stall, 0);
    next_cycle();
    applyStimulus(32'h0000_3004, 32'h0000_0101, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_SW, 1'b0, 32'h0);
    checkOutput("lw_mis_wb_we", wb_we, 0);
    checkOutput("lw_mis_wb_pc", wb_pc, 32'h3000);
    checkOutput("sw_mis_align", align_err, 1);
    checkOutput("sw_mis_req", ram_req, 0);

    // Store byte at offset 2
    next_cycle();
    applyStimulus(32'h0000_3008, 32'h0000_0006, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_SB, 1'b1, 32'h0);
    $display("[TB] store byte");
    checkOutput("sb_align", align_err, 0);
    checkOutput("sb_be", ram_be, 4'b0100);
    checkOutput("sb_wdata", ram_wdata, 32'hABAB_ABAB);
    checkOutput("sb_addr", ram_addr, 32'h1);
    checkOutput("sb_we", ram_we, 1);

    // Zero-wait load word and lbu at offset 0
    next_cycle();
    applyStimulus(32'h0000_3010, 32'h0000_0010, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, MEM_LOAD, 1'b1, 32'hCAFE_F00D);
    $display("[TB] zero-wait loads");
    checkOutput("lw_stall", stall, 0);
    next_cycle();
    applyStimulus(32'h0000_3014, 32'h0000_0004, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, MEM_LOAD, 1'b1, 32'h1122_3344);
    checkOutput("lw_wb_value", wb_value, 32'hCAFE_F00D);
    next_cycle();
    applyStimulus(32'h0000_3018, 32'h0000_0077, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_NONE, 1'b1, 32'h0);
    checkOutput("lbu0_wb_value", wb_value, 32'h0000_0044);
    checkOutput("idle_ack_req", ram_req, 0);
    checkOutput("idle_ack_stall", stall, 0);
    next_cycle();
    applyStimulus(32'h0000_4000, 32'h0000_0200, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, MEM_LOAD, 1'b0, 32'h0);
    checkOutput("idle_ack_wb_value", wb_value, 32'h77);

    // Timeout with TIMEOUT=4
    $display("[TB] timeout");
    checkOutput("to_stall_req", stall, 1);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); #2;
      checkOutput($sformatf("to_w%0d_stall", i), stall, 1);
      checkOutput($sformatf("to_w%0d_bus", i), bus_err, 0);
    end
    next_cycle(); #2;
    checkOutput("to_w4_bus", bus_err, 1);
    checkOutput("to_w4_req", ram_req, 0);
    checkOutput("to_w4_stall", stall, 1);
    next_cycle(); #2;
    checkOutput("to_rel_stall", stall, 0);
    checkOutput("to_rel_bus", bus_err, 0);
    checkOutput("to_rel_req", ram_req, 0);
    next_cycle();
    applyStimulus(32'h0000_4004, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_NONE, 1'b0, 32'h0);
    checkOutput("to_wb_we", wb_we, 0);
    checkOutput("to_wb_pc", wb_pc, 32'h4000);

    // Reset in the middle of a wait
    next_cycle();
    applyStimulus(32'h0000_5000, 32'h0000_0300, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, MEM_LOAD, 1'b0, 32'h0);
    $display("[TB] reset during wait");
    next_cycle(); #2;
    checkOutput("rw_wait_stall", stall, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, MEM_NONE, 1'b1, 32'h9999_9999);
    checkOutput("rw_stall", stall, 0);
    checkOutput("rw_req", ram_req, 0);
    checkOutput("rw_be", ram_be, 0);
    checkOutput("rw_we", ram_we, 0);
    checkOutput("rw_wb_pc", wb_pc, 0);
    checkOutput("rw_wb_value", wb_value, 0);
    checkOutput("rw_wb_syscall", wb_syscall, 0);
    next_cycle();
    ram_ack = 1'b0; #2;
    checkOutput("rw_late_wb_we", wb_we, 0);
    checkOutput("rw_late_wb_value", wb_value, 0);
    checkOutput("rw_late_req", ram_req, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
